// File: rtl/nes_pad_serializer.sv
// Console-facing emulation of NUM_PADS controller shift registers.
// Latch and pulse lines are sampled as data in the clk domain; nothing runs on them as a clock.
module nes_pad_serializer #(
  parameter int NUM_BUTTONS = 8,
  parameter int NUM_PADS    = 2,
  parameter int SYNC_STAGES = 2,
  parameter bit ACTIVE_LOW  = 1'b1,
  parameter bit FILL_LEVEL  = 1'b1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            latch_in,
  input  logic [NUM_PADS-1:0]             pulse_in,
  input  logic [NUM_PADS*NUM_BUTTONS-1:0] buttons,
  output logic [NUM_PADS-1:0]             data_out,
  output logic [NUM_PADS-1:0]             frame_done,
  output logic [NUM_PADS-1:0]             overrun
);

  localparam int CW = $clog2(NUM_BUTTONS + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(NUM_BUTTONS);
  localparam logic [CW-1:0] CNT_LAST = CW'(NUM_BUTTONS - 1);

  function automatic logic line(input logic b);
    return ACTIVE_LOW ? ~b : b;
  endfunction

  // Shared latch: only its level matters, so no edge-detect flop is kept.
  logic [SYNC_STAGES-1:0] latch_sync;
  logic                   latch_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) latch_sync <= '0;
    else        latch_sync <= {latch_sync[SYNC_STAGES-2:0], latch_in};
  end

  assign latch_s = latch_sync[SYNC_STAGES-1];

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    logic [SYNC_STAGES-1:0] pulse_sync;
    logic                   pulse_d;
    logic                   pulse_rise;
    logic [NUM_BUTTONS-1:0] slice;
    logic [NUM_BUTTONS-1:0] sr;
    logic [CW-1:0]          cnt;
    logic                   data_q;
    logic                   done_q;
    logic                   ovr_q;

    assign slice = buttons[p*NUM_BUTTONS +: NUM_BUTTONS];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        pulse_sync <= '0;
        pulse_d    <= 1'b0;
      end else begin
        pulse_sync <= {pulse_sync[SYNC_STAGES-2:0], pulse_in[p]};
        pulse_d    <= pulse_sync[SYNC_STAGES-1];
      end
    end

    assign pulse_rise = pulse_sync[SYNC_STAGES-1] & ~pulse_d;

    // Latch is transparent while high and overrides any pulse edge in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sr     <= '0;
        cnt    <= CNT_FULL;
        data_q <= FILL_LEVEL;
        done_q <= 1'b0;
        ovr_q  <= 1'b0;
      end else begin
        done_q <= 1'b0;
        if (latch_s) begin
          sr     <= slice;
          cnt    <= '0;
          data_q <= line(slice[0]);
          ovr_q  <= 1'b0;
        end else if (pulse_rise && cnt != CNT_FULL) begin
          sr  <= sr >> 1;
          cnt <= cnt + 1'b1;
          if (cnt != CNT_LAST) begin
            data_q <= line(sr[1]);
          end else begin
            data_q <= FILL_LEVEL;
            done_q <= 1'b1;
          end
        end else if (pulse_rise) begin
          data_q <= FILL_LEVEL;
          ovr_q  <= 1'b1;
        end
      end
    end

    assign data_out[p]   = data_q;
    assign frame_done[p] = done_q;
    assign overrun[p]    = ovr_q;
  end

endmodule

// File: tb/tb_nes_pad_serializer.sv
// Bench for nes_pad_serializer: randomized frames against a frame-queue reference model,
// with a per-pad monitor popping expected line levels after each console pulse.
module tb_nes_pad_serializer;

  localparam int NB = 8;
  localparam int NP = 2;
  localparam int SS = 2;
  localparam bit AL = 1'b1;
  localparam bit FL = 1'b1;

  logic              clk = 1'b0;
  logic              reset;
  logic              latch_in;
  logic [NP-1:0]     pulse_in;
  logic [NP*NB-1:0]  buttons;
  logic [NP-1:0]     data_out;
  logic [NP-1:0]     frame_done;
  logic [NP-1:0]     overrun;

  int checks   = 0;
  int failures = 0;

  // Expected monitor samples per pad: {frame_done, line level}.
  logic [1:0] exp_q   [NP][$];
  // Remaining samples of the latched frame per pad, built when the latch drops.
  logic [1:0] frame_q [NP][$];
  logic [NP-1:0] exp_ov;
  int exp_done [NP];
  int seen_done [NP];

  nes_pad_serializer #(
    .NUM_BUTTONS(NB), .NUM_PADS(NP), .SYNC_STAGES(SS),
    .ACTIVE_LOW(AL), .FILL_LEVEL(FL)
  ) dut (
    .clk(clk), .reset(reset), .latch_in(latch_in), .pulse_in(pulse_in),
    .buttons(buttons), .data_out(data_out), .frame_done(frame_done),
    .overrun(overrun)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic line_of(input logic b);
    return AL ? ~b : b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  for (genvar g = 0; g < NP; g++) begin : g_mon
    logic [1:0] e;
    always @(posedge pulse_in[g]) begin
      repeat (SS + 1) @(posedge clk);
      #1;
      if (exp_q[g].size() == 0) begin
        check($sformatf("pad%0d_queue_empty", g), 32'd1, 32'd0);
      end else begin
        e = exp_q[g].pop_front();
        check($sformatf("pad%0d_data", g), {31'd0, data_out[g]}, {31'd0, e[0]});
        check($sformatf("pad%0d_done", g), {31'd0, frame_done[g]}, {31'd0, e[1]});
      end
    end

    always @(negedge clk) if (reset && frame_done[g] === 1'b1) seen_done[g]++;
  end

  // ---------------- drivers ----------------
  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("reset_data", {30'd0, data_out}, {30'd0, {NP{FL}}});
    check("reset_done", {30'd0, frame_done}, 32'd0);
    check("reset_ovr", {30'd0, overrun}, 32'd0);
    for (int p = 0; p < NP; p++) frame_q[p].delete();
    exp_ov = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Hold latch for 12 cycles; optionally raise pulse_in[0] while it is high (must not shift).
  task automatic do_latch(input logic [NP*NB-1:0] btn, input bit with_pulse);
    buttons  = btn;
    latch_in = 1'b1;
    if (with_pulse) begin
      repeat (4) @(negedge clk);
      exp_q[0].push_back({1'b0, line_of(btn[0])});
      pulse_in[0] = 1'b1;
      repeat (6) @(negedge clk);
      pulse_in[0] = 1'b0;
      repeat (2) @(negedge clk);
    end else begin
      repeat (12) @(negedge clk);
    end
    latch_in = 1'b0;
    for (int p = 0; p < NP; p++) begin
      frame_q[p].delete();
      for (int i = 1; i < NB; i++) frame_q[p].push_back({1'b0, line_of(btn[p*NB + i])});
      frame_q[p].push_back({1'b1, FL});
    end
    exp_ov = '0;
    repeat (4) @(negedge clk);
    for (int p = 0; p < NP; p++)
      check($sformatf("latch_bit0_pad%0d", p), {31'd0, data_out[p]}, {31'd0, line_of(btn[p*NB])});
    check("latch_ovr_clear", {30'd0, overrun}, 32'd0);
  endtask

  task automatic do_pulse(input logic [NP-1:0] mask, input int hi, input int lo);
    for (int p = 0; p < NP; p++) begin
      if (mask[p]) begin
        if (frame_q[p].size() > 0) begin
          logic [1:0] e;
          e = frame_q[p].pop_front();
          if (e[1]) exp_done[p]++;
          exp_q[p].push_back(e);
        end else begin
          exp_q[p].push_back({1'b0, FL});
          exp_ov[p] = 1'b1;
        end
      end
    end
    pulse_in = pulse_in | mask;
    repeat (hi) @(negedge clk);
    pulse_in = pulse_in & ~mask;
    repeat (lo) @(negedge clk);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_ovr"}, {30'd0, overrun}, {30'd0, exp_ov});
    for (int p = 0; p < NP; p++)
      check($sformatf("%s_done_cnt%0d", tag, p), seen_done[p], exp_done[p]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset    = 1'b0;
    latch_in = 1'b0;
    pulse_in = '0;
    buttons  = '0;
    exp_ov   = '0;
    for (int p = 0; p < NP; p++) begin
      exp_done[p]  = 0;
      seen_done[p] = 0;
    end
    @(negedge clk);
    do_reset();

    // 1: pulses with no frame latched -> fill level, overrun on both pads
    do_pulse(2'b11, 6, 6);
    check_status("s1");

    // 2: known pattern on pad0
    do_latch({8'h00, 8'b1010_0101}, 1'b0);
    for (int i = 0; i < NB; i++) do_pulse(2'b01, 6, 6);
    check_status("s2");

    // 3: pad1 all pressed, pulses only on pad1
    do_latch({8'hFF, 8'h00}, 1'b0);
    for (int i = 0; i < NB; i++) do_pulse(2'b10, 6, 6);
    check("s3_pad0_idle", {31'd0, data_out[0]}, {31'd0, line_of(1'b0)});
    check_status("s3");

    // 4: buttons change mid-frame; latched snapshot must be used
    do_latch({8'h3C, 8'hC3}, 1'b0);
    for (int i = 0; i < 3; i++) do_pulse(2'b11, 5, 5);
    buttons = '0;
    for (int i = 3; i < NB; i++) do_pulse(2'b11, 5, 5);
    check_status("s4");

    // 5: pulse during latch, then a 9th pulse overruns, next latch clears it
    do_latch({8'h5A, 8'h96}, 1'b1);
    for (int i = 0; i < NB + 1; i++) do_pulse(2'b01, 4, 4);
    check_status("s5");
    do_latch({8'h01, 8'h80}, 1'b0);
    check_status("s5b");

    // 6: reset mid-frame, then a fresh frame reproduces scenario 2
    do_latch({8'h00, 8'b1010_0101}, 1'b0);
    for (int i = 0; i < 4; i++) do_pulse(2'b01, 6, 6);
    do_reset();
    do_latch({8'h00, 8'b1010_0101}, 1'b0);
    for (int i = 0; i < NB; i++) do_pulse(2'b01, 6, 6);
    check_status("s6");

    // Random frames: random buttons, pulse counts, pad masks and widths
    for (int f = 0; f < 12; f++) begin
      do_latch(16'($urandom()), 1'b0);
      for (int k = 0, n = $urandom_range(0, NB + 2); k < n; k++)
        do_pulse(2'($urandom_range(1, 3)), $urandom_range(SS + 1, 7), $urandom_range(SS + 1, 7));
      check_status($sformatf("rnd%0d", f));
    end

    repeat (10) @(negedge clk);
    for (int p = 0; p < NP; p++)
      check($sformatf("exp_q_drained%0d", p), exp_q[p].size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
